mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit for the MIPS datapath. It sits beside the combinational ALU and executes MULT, MULTU, DIV and DIVU iteratively, one result bit per clock. It owns the architectural HI/LO register pair and also services MTHI/MTLO writes. The pipeline controller starts an operation with a single-cycle Start pulse and stalls on Busy until Done.

## Interface
Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be ≥ 4.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  operation request; sampled only in IDLE.
- Op  input  3  operation select: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110 and 111 are no-ops.
- Src1  input  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- Src2  input  WIDTH  multiplier or divisor.
- Busy  output  1  high while an iterative operation is in flight.
- Done  output  1  one-cycle pulse: HI/LO just updated by MULT*/DIV*.
- Div_By_Zero  output  1  sticky per operation; set by DIV/DIVU with Src2 = 0, cleared at next accepted Start.
- HI  output  WIDTH  HI register: product upper half, or remainder.
- LO  output  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE, Start=1, Op = MULT*/DIV*:
  - latch operands; signed ops latch absolute values plus the result-sign bits;
  - load counter = WIDTH−1; go to RUN.
- Divide with Src2 = 0: go directly to FIX.
  - FIX writes HI = Src1 and LO = all ones, and sets Div_By_Zero.
- IDLE, Start=1, Op = MTHI/MTLO: write Src1 to HI or LO at that edge; no Busy, no Done.
- IDLE, Start=1, Op = 110/111: no-op; nothing changes.
- RUN, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- RUN, divide: restoring divide with a WIDTH+1-bit partial remainder, one quotient bit per cycle.
- RUN exit: when the counter reaches 0, go to FIX.
- FIX applies sign correction:
  - product negated in 2·WIDTH bits when the operand signs differ;
  - quotient negated when the signs differ (truncation toward zero);
  - remainder takes the dividend's sign.
- FIX then writes HI/LO, pulses Done, and returns to IDLE.
- Signed most-negative ÷ −1 wraps: LO = most-negative value, HI = 0. No trap is raised.
- Start while Busy is ignored; the operands are not re-latched.
- HI/LO hold their values between operations. They are never modified during RUN; intermediates live in internal registers.
- RST at any time, including mid-RUN, aborts the operation:
  - state → IDLE;
  - HI = 0, LO = 0, Busy = 0, Done = 0, Div_By_Zero = 0.

## Timing
- Reset values: HI = 0, LO = 0, Busy = 0, Done = 0, Div_By_Zero = 0.
- Let E0 be the edge that accepts Start:
  - Busy = 1 from after E0 until after E(WIDTH+1);
  - HI/LO valid and Done = 1 in the cycle after E(WIDTH+1), i.e. 33 cycles for WIDTH = 32.
- Divide by zero: Busy = 1 only for the cycle after E0. Done, HI/LO and Div_By_Zero update at E1.
- Busy and Done are never high together.
- Back-to-back operation: Start high in the Done cycle is accepted at the next edge, so there are no dead cycles.
- MTHI/MTLO: the new HI/LO value is visible in the cycle after the accepting edge.
- Outputs are registered; there is no combinational path from the inputs to the outputs.

## Test plan
- MULT, Src1 = 0xFFFFFFFE, Src2 = 0x00000003 → Done 33 cycles after Start, HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0x00000000, Div_By_Zero = 0.
- DIVU 5 / 0 → Done in the cycle after E1, HI = 0x00000005, LO = 0xFFFFFFFF, Div_By_Zero = 1. The next MULTU Start clears Div_By_Zero.
- Start pulsed again with different operands at cycle 10 of a MULT → ignored: the first result is unchanged and Done pulses once. MTLO 0x1234 while Busy → ignored; in IDLE → LO = 0x1234 the next cycle.
- RST asserted at cycle 15 of a DIV → IDLE next cycle with all outputs zero, no Done. A fresh DIVU 9 / 3 then gives LO = 3, HI = 0. Repeat the suite with WIDTH = 8: DIVU 0xFF / 0x10 → LO = 0x0F, HI = 0x0F, latency 9 cycles.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the pipeline controller and the
// iterative multiply/divide unit. The controller side drives the request,
// the unit side returns status and the architectural HI/LO registers.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] Src1;
    logic [WIDTH-1:0] Src2;
    logic             Busy;
    logic             Done;
    logic             Div_By_Zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, Src1, Src2,
        input  Busy, Done, Div_By_Zero, HI, LO
    );

    modport slave (
        input  Start, Op, Src1, Src2,
        output Busy, Done, Div_By_Zero, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the MIPS datapath. Produces one result
// bit per clock, owns the HI/LO register pair and also services MTHI/MTLO.
// Signed operations run on magnitudes and fix the signs in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RST,
    mult_div_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // multiply accumulator / quotient in low half
    logic [WIDTH:0]     rem;       // partial remainder, one guard bit
    logic [WIDTH-1:0]   op_b;      // multiplicand magnitude or divisor magnitude
    logic               is_div;
    logic               neg_res;   // product/quotient must be negated
    logic               neg_rem;   // remainder must be negated (dividend negative)
    logic               dz;        // divide-by-zero short path taken

    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               src1_neg;
    logic               src2_neg;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes; only signed ops (Op[0] set) look at the sign bits.
    assign src1_neg = bus.Op[0] & bus.Src1[WIDTH-1];
    assign src2_neg = bus.Op[0] & bus.Src2[WIDTH-1];
    assign abs1     = src1_neg ? -bus.Src1 : bus.Src1;
    assign abs2     = src2_neg ? -bus.Src2 : bus.Src2;

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit (acc[0]) is set, keeping the carry.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);

    // Restoring divide trial subtraction; a set MSB means "restore".
    assign trial    = {rem, acc[WIDTH-1]} - {2'b00, op_b};

    // Sign correction applied in the final cycle.
    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    // Control FSM, datapath iteration and architectural HI/LO in one block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            op_b    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (!bus.Op[2]) begin
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            is_div  <= bus.Op[1];
                            cnt     <= CW'(WIDTH - 1);
                            rem     <= '0;
                            neg_res <= src1_neg ^ src2_neg;
                            neg_rem <= src1_neg;
                            if (bus.Op[1]) begin
                                op_b <= abs2;
                                if (bus.Src2 == '0) begin
                                    // Keep the raw dividend: it goes to HI unchanged.
                                    acc   <= {{WIDTH{1'b0}}, bus.Src1};
                                    dz    <= 1'b1;
                                    state <= FIX;
                                end else begin
                                    acc   <= {{WIDTH{1'b0}}, abs1};
                                    dz    <= 1'b0;
                                    state <= RUN;
                                end
                            end else begin
                                op_b  <= abs1;
                                acc   <= {{WIDTH{1'b0}}, abs2};
                                dz    <= 1'b0;
                                state <= RUN;
                            end
                        end else if (!bus.Op[1]) begin
                            if (bus.Op[0]) begin
                                lo_q <= bus.Src1;
                            end else begin
                                hi_q <= bus.Src1;
                            end
                        end
                    end
                end

                RUN: begin
                    if (is_div) begin
                        if (!trial[WIDTH+1]) begin
                            rem              <= trial[WIDTH:0];
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem              <= {rem[WIDTH-1:0], acc[WIDTH-1]};
                            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (dz) begin
                        hi_q  <= acc[WIDTH-1:0];
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Div_By_Zero = dbz_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit at WIDTH = 32 and WIDTH = 8.
// Results are predicted with plain integer arithmetic on sign-extended values.
module tb_mult_div_unit;

    logic clk;
    logic rst32;
    logic rst8;
    int   checks;
    int   errors;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    mult_div_unit_if #(.WIDTH(32)) bus32 ();
    mult_div_unit_if #(.WIDTH(8))  bus8 ();

    mult_div_unit #(.WIDTH(32)) dut32 (.CLK(clk), .RST(rst32), .bus(bus32.slave));
    mult_div_unit #(.WIDTH(8))  dut8  (.CLK(clk), .RST(rst8),  .bus(bus8.slave));

    // Free-running clock shared by both instances.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_hi(input int w);
        return (w == 32) ? bus32.HI : {24'b0, bus8.HI};
    endfunction

    function automatic logic [31:0] get_lo(input int w);
        return (w == 32) ? bus32.LO : {24'b0, bus8.LO};
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 32) ? bus32.Busy : bus8.Busy;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 32) ? bus32.Done : bus8.Done;
    endfunction

    function automatic logic get_dbz(input int w);
        return (w == 32) ? bus32.Div_By_Zero : bus8.Div_By_Zero;
    endfunction

    // Reference: architectural result of MULT*/DIV* from integer arithmetic.
    function automatic void model(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz);
        logic [63:0] mask;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        mask = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        dbz = 1'b0;
        p = '0;
        if (!op[1]) begin
            if (op[0]) p = 64'(sa * sb);
            else       p = 64'(a) * 64'(b);
            hi = 32'((p >> w) & mask);
            lo = 32'(p & mask);
        end else if (b == '0) begin
            hi  = a;
            lo  = 32'(mask);
            dbz = 1'b1;
        end else if (op[0]) begin
            q  = sa / sb;
            r  = sa % sb;
            hi = 32'(64'(r) & mask);
            lo = 32'(64'(q) & mask);
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int w, input logic start, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            bus32.Start = start;
            bus32.Op    = op;
            bus32.Src1  = a;
            bus32.Src2  = b;
        end else begin
            bus8.Start = start;
            bus8.Op    = op;
            bus8.Src1  = a[7:0];
            bus8.Src2  = b[7:0];
        end
    endtask

    // Issue one MULT*/DIV*, optionally inject an extra Start at cycle gl_cycle,
    // then check latency, status and HI/LO against the model.
    task automatic check_output(input int w, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input int gl_cycle, input logic [2:0] gl_op,
                                input logic [31:0] gl_a, input string tag);
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        edbz;
        int          n;
        int          exp_lat;
        logic        got;
        model(w, op, a, b, ehi, elo, edbz);
        exp_lat = (op[1] && b == '0) ? 1 : w + 1;
        @(negedge clk);
        apply_stimulus(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        apply_stimulus(w, 1'b0, op, a, b);
        check({tag, "_busy_start"}, 64'(get_busy(w)), 64'd1);
        check({tag, "_dbz_cleared"}, 64'(get_dbz(w)), 64'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 2 * w + 10) begin
            @(posedge clk); #1;
            n++;
            apply_stimulus(w, 1'b0, op, a, b);
            if (get_done(w)) got = 1'b1;
            else if (n == gl_cycle) apply_stimulus(w, 1'b1, gl_op, gl_a, ~b);
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
        check({tag, "_hi"}, 64'(get_hi(w)), 64'(ehi));
        check({tag, "_lo"}, 64'(get_lo(w)), 64'(elo));
        check({tag, "_dbz"}, 64'(get_dbz(w)), 64'(edbz));
        @(posedge clk); #1;
        check({tag, "_done_once"}, 64'(get_done(w)), 64'd0);
    endtask

    task automatic move_to(input int w, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        apply_stimulus(w, 1'b1, op, a, 32'd0);
        @(posedge clk); #1;
        apply_stimulus(w, 1'b0, op, a, 32'd0);
    endtask

    task automatic random_ops(input int w, input int count);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m;
        logic [2:0]  op;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        for (int i = 0; i < count; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom & m;
            b  = $urandom & m;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'(1) << (w - 1); b = m; end
                default: ;
            endcase
            check_output(w, op, a, b, -1, OP_NOP, 32'd0, $sformatf("rnd%0d_%0d", w, i));
        end
    endtask

    // Directed and randomized sequence.
    initial begin
        int seen;
        checks = 0;
        errors = 0;
        rst32 = 1'b1;
        rst8  = 1'b1;
        apply_stimulus(32, 1'b0, OP_NOP, 32'd0, 32'd0);
        apply_stimulus(8,  1'b0, OP_NOP, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(get_hi(32)), 64'd0);
        check("rst_lo", 64'(get_lo(32)), 64'd0);
        check("rst_busy", 64'(get_busy(32)), 64'd0);
        check("rst_done", 64'(get_done(32)), 64'd0);
        check("rst_dbz", 64'(get_dbz(32)), 64'd0);
        check("rst8_lo", 64'(get_lo(8)), 64'd0);
        rst32 = 1'b0;
        rst8  = 1'b0;

        $display("[TB] WIDTH=32 directed operations");
        check_output(32, OP_MULT, 32'hFFFF_FFFE, 32'h3, -1, OP_NOP, 32'd0, "mult");
        check("mult_hi_const", 64'(get_hi(32)), 64'hFFFF_FFFF);
        check("mult_lo_const", 64'(get_lo(32)), 64'hFFFF_FFFA);
        check_output(32, OP_MULTU, 32'hFFFF_FFFE, 32'h3, -1, OP_NOP, 32'd0, "multu");
        check("multu_hi_const", 64'(get_hi(32)), 64'h2);
        check("multu_lo_const", 64'(get_lo(32)), 64'hFFFF_FFFA);
        check_output(32, OP_DIV, 32'hFFFF_FFF9, 32'h2, -1, OP_NOP, 32'd0, "div_neg7_2");
        check("div_lo_const", 64'(get_lo(32)), 64'hFFFF_FFFD);
        check("div_hi_const", 64'(get_hi(32)), 64'hFFFF_FFFF);
        check_output(32, OP_DIVU, 32'd100, 32'd7, -1, OP_NOP, 32'd0, "divu_100_7");
        check("divu_lo_const", 64'(get_lo(32)), 64'd14);
        check("divu_hi_const", 64'(get_hi(32)), 64'd2);
        check_output(32, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, OP_NOP, 32'd0, "div_wrap");
        check("wrap_lo_const", 64'(get_lo(32)), 64'h8000_0000);
        check("wrap_hi_const", 64'(get_hi(32)), 64'h0);
        check_output(32, OP_DIVU, 32'd5, 32'd0, -1, OP_NOP, 32'd0, "divu_by_zero");
        check("dz_hi_const", 64'(get_hi(32)), 64'h5);
        check("dz_lo_const", 64'(get_lo(32)), 64'hFFFF_FFFF);
        check("dz_flag_const", 64'(get_dbz(32)), 64'd1);
        check_output(32, OP_MULTU, 32'd12, 32'd11, -1, OP_NOP, 32'd0, "multu_after_dz");

        $display("[TB] Start and MTLO while busy");
        check_output(32, OP_MULT, 32'h0000_1235, 32'hFFFF_0F00, 10, OP_MULTU, 32'h7777_7777, "restart_ignored");
        check_output(32, OP_DIVU, 32'hDEAD_BEEF, 32'h0000_0123, 10, OP_MTLO, 32'h0000_1234, "mtlo_busy");
        move_to(32, OP_MTLO, 32'h0000_1234);
        check("mtlo_lo", 64'(get_lo(32)), 64'h1234);
        check("mtlo_busy_low", 64'(get_busy(32)), 64'd0);
        check("mtlo_no_done", 64'(get_done(32)), 64'd0);
        move_to(32, OP_MTHI, 32'hCAFE_F00D);
        check("mthi_hi", 64'(get_hi(32)), 64'hCAFE_F00D);
        check("mthi_lo_kept", 64'(get_lo(32)), 64'h1234);
        move_to(32, OP_NOP, 32'h5555_5555);
        check("nop_hi", 64'(get_hi(32)), 64'hCAFE_F00D);
        check("nop_lo", 64'(get_lo(32)), 64'h1234);
        check("nop_busy", 64'(get_busy(32)), 64'd0);

        $display("[TB] Reset during divide");
        @(negedge clk);
        apply_stimulus(32, 1'b1, OP_DIV, 32'h1234_5678, 32'h0000_0011);
        @(posedge clk); #1;
        apply_stimulus(32, 1'b0, OP_DIV, 32'h1234_5678, 32'h0000_0011);
        repeat (14) @(posedge clk);
        #1;
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        check("midrst_hi", 64'(get_hi(32)), 64'd0);
        check("midrst_lo", 64'(get_lo(32)), 64'd0);
        check("midrst_busy", 64'(get_busy(32)), 64'd0);
        check("midrst_done", 64'(get_done(32)), 64'd0);
        check("midrst_dbz", 64'(get_dbz(32)), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (get_done(32) || get_busy(32)) seen++;
        end
        check("midrst_quiet", 64'(seen), 64'd0);
        check_output(32, OP_DIVU, 32'd9, 32'd3, -1, OP_NOP, 32'd0, "divu_9_3");
        check("div93_lo_const", 64'(get_lo(32)), 64'd3);
        check("div93_hi_const", 64'(get_hi(32)), 64'd0);

        $display("[TB] WIDTH=32 random operations");
        random_ops(32, 40);

        $display("[TB] WIDTH=8 operations");
        check_output(8, OP_DIVU, 32'hFF, 32'h10, -1, OP_NOP, 32'd0, "w8_divu");
        check("w8_lo_const", 64'(get_lo(8)), 64'h0F);
        check("w8_hi_const", 64'(get_hi(8)), 64'h0F);
        check_output(8, OP_DIV, 32'h80, 32'hFF, -1, OP_NOP, 32'd0, "w8_wrap");
        check("w8_wrap_lo", 64'(get_lo(8)), 64'h80);
        check_output(8, OP_MULT, 32'hFE, 32'h03, -1, OP_NOP, 32'd0, "w8_mult");
        check("w8_mult_hi", 64'(get_hi(8)), 64'hFF);
        check("w8_mult_lo", 64'(get_lo(8)), 64'hFA);
        random_ops(8, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
